// File: rtl/dca_matrix_lsu_responder.sv
// Matrix LSU responder: turns one block-load/store instruction into per-row
// memory requests, tracks outstanding read rows and forwards returned rows.
module dca_matrix_lsu_responder #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned ELEM_W          = 8,
  parameter int unsigned MAX_DIM         = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        enable,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  input  logic                        inst_opcode,
  input  logic [ADDR_W-1:0]           inst_addr,
  input  logic [ADDR_W-1:0]           inst_stride,
  input  logic [3:0]                  inst_num_row,
  input  logic [3:0]                  inst_num_col,
  output logic                        mreq_valid,
  input  logic                        mreq_ready,
  output logic                        mreq_write,
  output logic [ADDR_W-1:0]           mreq_addr,
  output logic [MAX_DIM*ELEM_W/8-1:0] mreq_byte_en,
  output logic [MAX_DIM*ELEM_W-1:0]   mreq_wdata,
  input  logic                        mresp_valid,
  output logic                        mresp_ready,
  input  logic [MAX_DIM*ELEM_W-1:0]   mresp_data,
  output logic                        rrow_valid,
  input  logic                        rrow_ready,
  output logic [MAX_DIM*ELEM_W-1:0]   rrow_data,
  output logic                        rrow_last,
  input  logic                        wrow_valid,
  output logic                        wrow_ready,
  input  logic [MAX_DIM*ELEM_W-1:0]   wrow_data,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned DATA_W = MAX_DIM * ELEM_W;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [3:0]        num_row_q, num_row_d;
  logic [3:0]        num_col_q, num_col_d;
  logic [CNT_W-1:0]  iss_q, iss_d;
  logic [CNT_W-1:0]  rsp_q, rsp_d;
  logic              done_q, done_d;

  logic              active;
  logic              is_read;
  logic [CNT_W:0]    outstanding;
  logic [CNT_W-1:0]  last_idx;
  logic              mreq_hs;
  logic              mresp_hs;

  assign active      = (state_q != S_IDLE);
  assign is_read     = ~op_q;
  assign last_idx    = num_row_q - 4'd1;
  assign outstanding = {1'b0, iss_q} - {1'b0, rsp_q};

  // Handshake-facing outputs are combinational views of the registered state
  assign inst_ready   = (state_q == S_IDLE) & enable & ~clear;
  assign mreq_write   = op_q;
  assign mreq_addr    = addr_q;
  assign mreq_wdata   = wrow_data;
  assign mresp_ready  = active & is_read & rrow_ready;
  assign rrow_valid   = active & is_read & mresp_valid;
  assign rrow_data    = mresp_data;
  assign rrow_last    = (rsp_q == last_idx);
  assign wrow_ready   = (state_q == S_ISSUE) & op_q & mreq_ready;
  assign busy         = active;
  assign done         = done_q;

  assign mreq_hs  = mreq_valid & mreq_ready;
  assign mresp_hs = mresp_valid & mresp_ready;

  always_comb begin
    mreq_valid = 1'b0;
    if (enable && state_q == S_ISSUE) begin
      if (is_read) mreq_valid = (outstanding < (CNT_W+1)'(MAX_OUTSTANDING));
      else         mreq_valid = wrow_valid;
    end
  end

  // Enable the low num_col*ELEM_W/8 byte lanes
  always_comb begin
    mreq_byte_en = '0;
    for (int k = 0; k < int'(BE_W); k++) begin
      mreq_byte_en[k] = (k < (int'(num_col_q) * int'(ELEM_W)) / 8);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    num_row_d = num_row_q;
    num_col_d = num_col_q;
    iss_d     = iss_q;
    rsp_d     = rsp_q;
    done_d    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      iss_d   = '0;
      rsp_d   = '0;
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (inst_valid) begin
            op_d      = inst_opcode;
            addr_d    = inst_addr;
            stride_d  = inst_stride;
            num_row_d = inst_num_row;
            num_col_d = inst_num_col;
            iss_d     = '0;
            rsp_d     = '0;
            if (inst_num_row == 4'd0) done_d  = 1'b1;
            else                      state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mreq_hs) begin
            iss_d  = iss_q + CNT_W'(1);
            addr_d = addr_q + stride_q;
          end
          if (is_read) begin
            if (mresp_hs) rsp_d = rsp_q + CNT_W'(1);
            if (mreq_hs && iss_q == last_idx) state_d = S_DRAIN;
          end else if (mreq_hs && iss_q == last_idx) begin
            // Writes are posted: finish as soon as the last row is accepted
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        S_DRAIN: begin
          if (mresp_hs) begin
            rsp_d = rsp_q + CNT_W'(1);
            if (rsp_q == last_idx) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      addr_q    <= '0;
      stride_q  <= '0;
      num_row_q <= '0;
      num_col_q <= '0;
      iss_q     <= '0;
      rsp_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      num_row_q <= num_row_d;
      num_col_q <= num_col_d;
      iss_q     <= iss_d;
      rsp_q     <= rsp_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: doc/dca_matrix_lsu_responder.md
DCA_MATRIX_LSU_RESPONDER -- requirements
Module: dca_matrix_lsu_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, byte address width; ELEM_W, default 8, element width in bits; MAX_DIM, default 8, maximum rows and columns per block; MAX_OUTSTANDING, default 4, maximum number of read rows in flight.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort.
- enable  in  1  state-advance qualifier.
- inst_valid  in  1  LSU instruction valid.
- inst_ready  out  1  LSU instruction accepted.
- inst_opcode  in  1  0=READ, 1=WRITE.
- inst_addr  in  ADDR_W  block base address.
- inst_stride  in  ADDR_W  row pitch in bytes.
- inst_num_row  in  4  valid rows, 0..MAX_DIM.
- inst_num_col  in  4  valid columns, 0..MAX_DIM.
- mreq_valid  out  1  memory request valid.
- mreq_ready  in  1  memory request accepted.
- mreq_write  out  1  1=write request.
- mreq_addr  out  ADDR_W  row address.
- mreq_byte_en  out  MAX_DIM*ELEM_W/8  element enables.
- mreq_wdata  out  MAX_DIM*ELEM_W  write row data.
- mresp_valid  in  1  read row returned.
- mresp_ready  out  1  read row consumed.
- mresp_data  in  MAX_DIM*ELEM_W  read row data.
- rrow_valid  out  1  read row to datapath.
- rrow_ready  in  1  datapath accepts the read row.
- rrow_data  out  MAX_DIM*ELEM_W  read row data.
- rrow_last  out  1  final row of the block.
- wrow_valid  in  1  write row from datapath.
- wrow_ready  out  1  write row consumed.
- wrow_data  in  MAX_DIM*ELEM_W  write row data.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and DRAIN; busy = (state != IDLE).
REQ-004 inst_ready = (state == IDLE) & enable & ~clear; on acceptance the block SHALL latch opcode, addr, stride, num_row and num_col, and SHALL zero the issue counter (iss) and the response counter (rsp).
REQ-005 Accepting an instruction with num_row=0 SHALL stay in IDLE, SHALL pulse done in the next cycle and SHALL issue no request.
REQ-006 Otherwise the FSM SHALL go to ISSUE; mreq_addr = addr + iss*stride, computed modulo 2^ADDR_W (wrap-around, no error).
REQ-007 mreq_byte_en bit k SHALL be 1 iff k < num_col*ELEM_W/8; num_col=0 SHALL issue requests with all enables zero.
REQ-008 READ, ISSUE: mreq_valid = 1 iff (iss - rsp) < MAX_OUTSTANDING; when (iss - rsp) == MAX_OUTSTANDING, a response handshake in the same cycle SHALL NOT unblock issue until the next cycle.
REQ-009 READ: mresp_ready = rrow_ready in ISSUE/DRAIN; rrow_valid = mresp_valid; rrow_data = mresp_data; rrow_last = (rsp == num_row-1); each mresp handshake increments rsp.
REQ-010 READ: when iss reaches num_row, the FSM SHALL enter DRAIN; when the last response is handshaken it SHALL return to IDLE and pulse done in the next cycle.
REQ-011 WRITE, ISSUE: mreq_valid = wrow_valid; mreq_wdata = wrow_data; wrow_ready = mreq_ready; after the handshake with iss == num_row-1 the FSM SHALL return to IDLE and pulse done next cycle, with no response tracking (writes are posted).
REQ-012 The iss counter SHALL increment on each mreq handshake; mreq_valid, mresp_ready and wrow_ready SHALL be 0 in IDLE.
REQ-013 enable=0 SHALL hold all state and counters and SHALL force inst_ready=0 and mreq_valid=0; handshakes on mresp and wrow remain combinational passthrough.
REQ-014 clear=1 SHALL synchronously force IDLE, zero the counters and suppress done, and SHALL take precedence over enable and over any handshake in the same cycle.
REQ-015 Responses arriving in IDLE SHALL be ignored (mresp_ready=0).

Reset
REQ-016 While rst=1 the block SHALL be in state IDLE with iss=rsp=0, all latched fields 0, and done=busy=mreq_valid=rrow_valid=wrow_ready=mresp_ready=0.
REQ-017 Deassertion of rst SHALL take effect at the next clock edge; an assertion of rst during an instruction SHALL abandon it without a done pulse.

Verification
REQ-018 READ, addr=0x1000, stride=0x40, rows=3, cols=8, ready always 1 -> mreq_addr 0x1000/0x1040/0x1080 with byte_en=0xFF, rrow_last on the 3rd row, one done pulse.
REQ-019 READ, rows=8, MAX_OUTSTANDING=4, mresp stalled -> exactly 4 requests issued; then 1 response -> 5th request issued the following cycle.
REQ-020 WRITE, rows=2, cols=3, wrow_valid delayed 5 cycles -> no mreq until wrow_valid; byte_en=0x07; done one cycle after the 2nd handshake.
REQ-021 addr=0xFFFFFFC0, stride=0x40, rows=2 -> 2nd address = 0x00000000.
REQ-022 rows=0 -> no mreq, done one cycle after acceptance; clear during DRAIN -> IDLE, no done; rst mid-ISSUE -> all outputs at 0.
